// File: rtl/event_packetizer.sv
// event_packetizer: buffers 64-bit pulse records in a small FIFO and serializes
// each one as a SYNC-framed MSB-first byte stream. Optional macro: CHECKSUM_EN.
module event_packetizer #(
    parameter int         DEPTH_LOG2 = 3,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         OVF_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           event_data,
    input  logic                  event_ready,
    output logic                  halt,
    output logic [7:0]            out_byte,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [OVF_W-1:0]      ovf_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
`ifdef CHECKSUM_EN
        , ST_CSUM = 2'd3
`endif
    } state_t;

    logic [63:0]      mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]    level, level_d;
    logic [OVF_W-1:0] ovf_count_q;
    logic             halt_q, halt_d;
    state_t           state_q;
    logic [63:0]      shreg_q;
    logic [2:0]       idx_q;
    logic [7:0]       out_byte_q;
    logic             out_valid_q;
`ifdef CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    logic empty, full, push, drop, ack, frame_done, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    // A same-cycle pop does not make room for a push that arrives while full.
    assign push  = event_ready && !full;
    assign drop  = event_ready && full;
    assign ack   = out_valid_q && out_ack;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // frame_done unassigned, which would otherwise infer a latch.
        frame_done = 1'b0;
        case (state_q)
`ifdef CHECKSUM_EN
            ST_CSUM: frame_done = ack;
`else
            ST_DATA: frame_done = ack && (idx_q == 3'd7);
`endif
            default: frame_done = 1'b0;
        endcase
    end

    // Popping at the final ack lets the next frame follow without an idle gap.
    assign pop     = !empty && ((state_q == ST_IDLE) || frame_done);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign level_d = level + PW'(push) - PW'(pop);
    assign halt_d  = (level_d >= PW'(DEPTH - 1));

    // NOTE: the record storage has no reset; resetting the pointers is enough
    // to discard its contents, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-2:0]] <= event_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovf_count_q <= '0;
            halt_q      <= 1'b0;
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            halt_q   <= halt_d;
            if (drop && (ovf_count_q != {OVF_W{1'b1}})) begin
                ovf_count_q <= ovf_count_q + OVF_W'(1);
            end

            if (pop) begin
                shreg_q     <= mem_q[rd_ptr_q[PW-2:0]];
                out_byte_q  <= SYNC_BYTE;
                out_valid_q <= 1'b1;
                state_q     <= ST_SYNC;
            end else begin
                case (state_q)
                    ST_IDLE: out_valid_q <= 1'b0;
                    ST_SYNC: begin
                        if (ack) begin
                            out_byte_q <= shreg_q[63:56];
                            idx_q      <= '0;
                            state_q    <= ST_DATA;
`ifdef CHECKSUM_EN
                            csum_q     <= shreg_q[63:56];
`endif
                        end
                    end
                    ST_DATA: begin
                        if (ack) begin
                            if (idx_q == 3'd7) begin
`ifdef CHECKSUM_EN
                                out_byte_q  <= csum_q;
                                state_q     <= ST_CSUM;
`else
                                out_valid_q <= 1'b0;
                                state_q     <= ST_IDLE;
`endif
                            end else begin
                                shreg_q    <= {shreg_q[55:0], 8'h00};
                                out_byte_q <= shreg_q[55:48];
                                idx_q      <= idx_q + 3'd1;
`ifdef CHECKSUM_EN
                                csum_q     <= csum_q ^ shreg_q[55:48];
`endif
                            end
                        end
                    end
`ifdef CHECKSUM_EN
                    ST_CSUM: begin
                        if (ack) begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
`endif
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign halt       = halt_q;
    assign out_byte   = out_byte_q;
    assign out_valid  = out_valid_q;
    assign fifo_level = level;
    assign ovf_count  = ovf_count_q;

endmodule
